// File: rtl/cpg_pkg.sv
// Shared types and helpers for the CNN output gather block.
package cpg_pkg;

  localparam int PIX_W           = 16;
  localparam int PIX_W1          = PIX_W + 1;
  localparam int NUM_CNN_OUTPUTS = 5;

  typedef logic signed [PIX_W-1:0] pixel_t;

  typedef enum logic {
    GATHER = 1'b0,
    EMIT   = 1'b1
  } gather_state_t;

  typedef struct packed {
    pixel_t val;
    logic   ovf;
  } sat_res_t;

  // Signed add at one extra bit of headroom, clamped to the pixel range.
  function automatic sat_res_t sat_add(pixel_t a, int off);
    logic signed [PIX_W:0] a_ext;
    logic signed [PIX_W:0] o_ext;
    logic signed [PIX_W:0] s;
    sat_res_t              r;
    a_ext = $signed({a[PIX_W-1], a});
    o_ext = $signed(PIX_W1'(off));
    s     = a_ext + o_ext;
    r.ovf = (s[PIX_W] != s[PIX_W-1]);
    if (r.ovf) r.val = s[PIX_W] ? {1'b1, {(PIX_W-1){1'b0}}} : {1'b0, {(PIX_W-1){1'b1}}};
    else       r.val = s[PIX_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/axis_slot.sv
// One-word AXI-Stream capture slot: holds a single offset-adjusted word
// until the gather FSM drains the packet and clears it.
module axis_slot
  import cpg_pkg::*;
#(
  parameter int OFFSET = 0
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   en_i,      // gather phase and out of reset
  input  logic   clr_i,     // packet fully emitted
  input  pixel_t tdata_i,
  input  logic   tvalid_i,
  output logic   tready_o,
  output logic   accept_o,
  output logic   ovf_o,
  output logic   full_o,
  output pixel_t slot_o
);

  logic     full_q, full_d;
  pixel_t   slot_q, slot_d;
  sat_res_t adj;

  // Ready depends only on registered state, never on tvalid.
  always_comb begin
    adj      = sat_add(tdata_i, OFFSET);
    tready_o = en_i & ~full_q;
    accept_o = tvalid_i & tready_o;
    ovf_o    = adj.ovf;
    full_d   = full_q;
    slot_d   = slot_q;
    if (clr_i) begin
      full_d = 1'b0;
    end else if (accept_o) begin
      full_d = 1'b1;
      slot_d = adj.val;
    end
  end

  // Slot and full-bit registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      slot_q <= '0;
    end else begin
      full_q <= full_d;
      slot_q <= slot_d;
    end
  end

  assign full_o = full_q;
  assign slot_o = slot_q;

endmodule

// File: rtl/cnn_output_gather.sv
// Joins five single-word CNN result streams into one 5-word AXI-Stream
// packet, shifting the centroid channels from crop to frame coordinates.
module cnn_output_gather
  import cpg_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = PIX_W,
  parameter int Y_1             = 10,
  parameter int X_1             = 10,
  parameter int X_IDX           = 1,
  parameter int Y_IDX           = 2,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic [PIXEL_BIT_WIDTH-1:0] cnn_output_0_TDATA,
  input  logic                       cnn_output_0_TVALID,
  output logic                       cnn_output_0_TREADY,
  input  logic [PIXEL_BIT_WIDTH-1:0] cnn_output_1_TDATA,
  input  logic                       cnn_output_1_TVALID,
  output logic                       cnn_output_1_TREADY,
  input  logic [PIXEL_BIT_WIDTH-1:0] cnn_output_2_TDATA,
  input  logic                       cnn_output_2_TVALID,
  output logic                       cnn_output_2_TREADY,
  input  logic [PIXEL_BIT_WIDTH-1:0] cnn_output_3_TDATA,
  input  logic                       cnn_output_3_TVALID,
  output logic                       cnn_output_3_TREADY,
  input  logic [PIXEL_BIT_WIDTH-1:0] cnn_output_4_TDATA,
  input  logic                       cnn_output_4_TVALID,
  output logic                       cnn_output_4_TREADY,
  output logic [PIXEL_BIT_WIDTH-1:0] gather_output_TDATA,
  output logic                       gather_output_TVALID,
  input  logic                       gather_output_TREADY,
  output logic                       gather_output_TLAST,
  output logic                       sat_flag,
  output logic [CNT_WIDTH-1:0]       packet_count
);

  localparam int N = NUM_CNN_OUTPUTS;

  logic [1:0]                          rst_pipe_q;
  logic                                rst_n_int;
  logic [N-1:0][PIXEL_BIT_WIDTH-1:0]   tdata_in, slot;
  logic [N-1:0]                        tvalid_in, tready, accept, ovf, full;
  gather_state_t                       state_q, state_d;
  logic [2:0]                          idx_q, idx_d;
  logic                                sat_q, sat_d;
  logic [CNT_WIDTH-1:0]                cnt_q, cnt_d;
  logic                                en, hs, last_hs, gather_done;

  // Reset asserts asynchronously, releases two clocks later.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) rst_pipe_q <= 2'b00;
    else           rst_pipe_q <= {rst_pipe_q[0], 1'b1};
  end
  assign rst_n_int = rst_pipe_q[1];

  assign tdata_in  = {cnn_output_4_TDATA, cnn_output_3_TDATA, cnn_output_2_TDATA,
                      cnn_output_1_TDATA, cnn_output_0_TDATA};
  assign tvalid_in = {cnn_output_4_TVALID, cnn_output_3_TVALID, cnn_output_2_TVALID,
                      cnn_output_1_TVALID, cnn_output_0_TVALID};
  assign {cnn_output_4_TREADY, cnn_output_3_TREADY, cnn_output_2_TREADY,
          cnn_output_1_TREADY, cnn_output_0_TREADY} = tready;

  assign en          = (state_q == GATHER) & rst_n_int;
  assign hs          = (state_q == EMIT) & gather_output_TREADY;
  assign last_hs     = hs & (idx_q == 3'd4);
  assign gather_done = en & (&(full | accept));

  for (genvar k = 0; k < N; k++) begin : g_slot
    localparam int OFF = (k == X_IDX) ? X_1 : ((k == Y_IDX) ? Y_1 : 0);
    axis_slot #(.OFFSET(OFF)) u_slot (
      .clk_i    (ap_clk),
      .rst_ni   (rst_n_int),
      .en_i     (en),
      .clr_i    (last_hs),
      .tdata_i  (tdata_in[k]),
      .tvalid_i (tvalid_in[k]),
      .tready_o (tready[k]),
      .accept_o (accept[k]),
      .ovf_o    (ovf[k]),
      .full_o   (full[k]),
      .slot_o   (slot[k])
    );
  end

  // State, word index, saturation flag and packet counter registers.
  always_ff @(posedge ap_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q <= GATHER;
      idx_q   <= '0;
      sat_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: leave GATHER once every slot is (or is becoming) full.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sat_d   = sat_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      GATHER: begin
        sat_d = sat_q | (|(accept & ovf));
        if (gather_done) begin
          state_d = EMIT;
          idx_d   = '0;
        end
      end
      EMIT: begin
        if (last_hs) begin
          state_d = GATHER;
          idx_d   = '0;
          sat_d   = 1'b0;
          cnt_d   = cnt_q + 1'b1;
        end else if (hs) begin
          idx_d = idx_q + 3'd1;
        end
      end
      default: state_d = GATHER;
    endcase
  end

  // Outputs: stream the slots in channel order while in EMIT.
  always_comb begin
    gather_output_TVALID = 1'b0;
    gather_output_TLAST  = 1'b0;
    gather_output_TDATA  = '0;
    if (state_q == EMIT) begin
      gather_output_TVALID = 1'b1;
      gather_output_TLAST  = (idx_q == 3'd4);
      gather_output_TDATA  = slot[idx_q];
    end
  end

  assign sat_flag     = sat_q;
  assign packet_count = cnt_q;

endmodule

// File: tb/tb_cnn_output_gather.sv
// Randomized scoreboard bench for cnn_output_gather.
module tb_cnn_output_gather;
  localparam int CW = 4;

  typedef struct {
    int data;
    bit last;
    bit sat;
    int cnt;
  } exp_t;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic [15:0] td [5];
  logic        tv [5];
  logic        tr [5];
  logic [15:0] gdata;
  logic        gvalid, glast, gready, satf;
  logic [CW-1:0] pcnt;

  int   n_chk = 0, n_pass = 0;
  int   cyc = 0, mon_words = 0, pkts_pushed = 0;
  int   rdy_mode = 0;
  int   chq [5][$];
  exp_t sb [$];

  cnn_output_gather #(.CNT_WIDTH(CW)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .cnn_output_0_TDATA(td[0]), .cnn_output_0_TVALID(tv[0]), .cnn_output_0_TREADY(tr[0]),
    .cnn_output_1_TDATA(td[1]), .cnn_output_1_TVALID(tv[1]), .cnn_output_1_TREADY(tr[1]),
    .cnn_output_2_TDATA(td[2]), .cnn_output_2_TVALID(tv[2]), .cnn_output_2_TREADY(tr[2]),
    .cnn_output_3_TDATA(td[3]), .cnn_output_3_TVALID(tv[3]), .cnn_output_3_TREADY(tr[3]),
    .cnn_output_4_TDATA(td[4]), .cnn_output_4_TVALID(tv[4]), .cnn_output_4_TREADY(tr[4]),
    .gather_output_TDATA(gdata), .gather_output_TVALID(gvalid),
    .gather_output_TREADY(gready), .gather_output_TLAST(glast),
    .sat_flag(satf), .packet_count(pcnt)
  );

  always #5 ap_clk = ~ap_clk;

  initial forever begin
    @(posedge ap_clk);
    cyc++;
  end

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference adjustment: frame coordinate = crop coordinate + origin, clamped.
  function automatic int ref_adj(int k, int v, output bit ov);
    int s;
    s  = v + ((k == 1) ? 10 : (k == 2) ? 10 : 0);
    ov = 0;
    if (s > 32767)  begin s = 32767;  ov = 1; end
    if (s < -32768) begin s = -32768; ov = 1; end
    return s;
  endfunction

  task automatic send_pkt(int d0, int d1, int d2, int d3, int d4);
    int   d [5];
    int   e [5];
    bit   any_ov, ov;
    exp_t x;
    d = '{d0, d1, d2, d3, d4};
    any_ov = 0;
    for (int k = 0; k < 5; k++) begin
      chq[k].push_back(d[k]);
      e[k] = ref_adj(k, d[k], ov);
      any_ov |= ov;
    end
    for (int k = 0; k < 5; k++) begin
      x.data = e[k] & 16'hFFFF;
      x.last = (k == 4);
      x.sat  = any_ov;
      x.cnt  = pkts_pushed % (1 << CW);
      sb.push_back(x);
    end
    pkts_pushed++;
  endtask

  // Producer for one channel: offers queued words with random idle gaps.
  task automatic run_chan(int k, int nw, int maxgap, int predelay);
    int v, guard;
    repeat (predelay) @(posedge ap_clk);
    for (int n = 0; n < nw; n++) begin
      repeat ($urandom_range(0, maxgap)) @(posedge ap_clk);
      #1;
      v = chq[k].pop_front();
      td[k] = 16'(v);
      tv[k] = 1'b1;
      guard = 0;
      forever begin
        @(negedge ap_clk);
        if (tr[k]) break;
        if (++guard > 3000) begin
          chk($sformatf("ch%0d_accept_timeout", k), 0, 1);
          break;
        end
      end
      @(posedge ap_clk);
      #1;
      tv[k] = 1'b0;
    end
  endtask

  task automatic run_all(int nw, int maxgap);
    fork
      run_chan(0, nw, maxgap, 0);
      run_chan(1, nw, maxgap, 0);
      run_chan(2, nw, maxgap, 0);
      run_chan(3, nw, maxgap, 0);
      run_chan(4, nw, maxgap, 0);
    join
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 5000) begin
      @(posedge ap_clk);
      guard++;
    end
    chk("drain_timeout", sb.size(), 0);
    repeat (2) @(posedge ap_clk);
  endtask

  // Downstream ready: 0 = always ready, 1 = random, 2 = held by the main thread.
  initial forever begin
    @(posedge ap_clk);
    #1;
    if (rdy_mode == 0)      gready = 1'b1;
    else if (rdy_mode == 1) gready = 1'($urandom_range(0, 1));
  end

  // Monitor: compare every accepted word against the scoreboard; check AXI hold.
  initial begin
    bit        prev_stall = 0;
    logic [15:0] prev_data = '0;
    exp_t      x;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin
        prev_stall = 0;
        continue;
      end
      if (prev_stall) chk("hold_under_backpressure", {gvalid, gdata}, {1'b1, prev_data});
      if (gvalid && gready) begin
        mon_words++;
        if (sb.size() == 0) begin
          chk("unexpected_word", int'(gdata), -1);
        end else begin
          x = sb.pop_front();
          chk("word_data", int'(gdata), x.data);
          chk("word_last", int'(glast), int'(x.last));
          chk("word_sat",  int'(satf), int'(x.sat));
          chk("word_pcnt", int'(pcnt), x.cnt);
        end
      end
      prev_stall = gvalid && !gready;
      prev_data  = gdata;
    end
  end

  initial begin
    int cap3, fv, guard, seen, base, r;
    for (int k = 0; k < 5; k++) begin tv[k] = 1'b0; td[k] = '0; end
    gready = 1'b1;

    // Reset state.
    repeat (3) @(posedge ap_clk);
    #1;
    for (int k = 0; k < 5; k++) chk($sformatf("rst_tready%0d", k), int'(tr[k]), 0);
    chk("rst_tvalid", int'(gvalid), 0);
    chk("rst_tlast", int'(glast), 0);
    chk("rst_tdata", int'(gdata), 0);
    chk("rst_sat", int'(satf), 0);
    chk("rst_pcnt", int'(pcnt), 0);
    ap_rst_n = 1'b1;
    repeat (4) @(posedge ap_clk);

    // Single packet, all channels together.
    send_pkt(100, 20, 30, 4, 5);
    run_all(1, 0);
    drain();
    chk("t1_pcnt", int'(pcnt), 1);
    chk("t1_sat", int'(satf), 0);

    // Staggered arrival: channel 3 late, others offer a second word while full.
    send_pkt(1, 2, 3, 4, 5);
    send_pkt(6, 7, 8, 9, 10);
    cap3 = -1; fv = -2;
    fork
      run_chan(0, 2, 0, 0);
      run_chan(1, 2, 0, 0);
      run_chan(2, 2, 0, 0);
      run_chan(3, 2, 0, 50);
      run_chan(4, 2, 0, 0);
      begin
        repeat (20) @(negedge ap_clk);
        chk("stall_ch0_offered", int'(tv[0]), 1);
        chk("stall_ch0_tready", int'(tr[0]), 0);
      end
      begin
        guard = 0;
        while (!(tv[3] && tr[3]) && guard < 500) begin @(negedge ap_clk); guard++; end
        cap3 = cyc + 1;
        guard = 0;
        while (!gvalid && guard < 500) begin @(negedge ap_clk); guard++; end
        fv = cyc;
      end
    join
    chk("first_valid_latency", fv, cap3);
    drain();

    // Saturation, then a clean packet.
    send_pkt(7, 32760, -5, 1, 2);
    send_pkt(1, 2, 3, 4, 5);
    send_pkt(0, -32768, 32767, 0, 0);
    run_all(3, 2);
    drain();
    chk("sat_cleared", int'(satf), 0);

    // Random data under random back-pressure.
    rdy_mode = 1;
    for (int p = 0; p < 20; p++) begin
      r = $urandom_range(0, 3);
      send_pkt(int'($signed(16'($urandom))), (r == 0) ? 32767 - $urandom_range(0, 15) : int'($signed(16'($urandom))),
               int'($signed(16'($urandom))), int'($signed(16'($urandom))), int'($signed(16'($urandom))));
    end
    run_all(20, 3);
    drain();
    rdy_mode = 0;
    repeat (2) @(posedge ap_clk);
    #1;
    chk("bp_pcnt_wrapped", int'(pcnt), pkts_pushed % (1 << CW));

    // Reset while packet is mid-emission.
    rdy_mode = 2;
    gready = 1'b1;
    base = mon_words;
    send_pkt(11, 22, 33, 44, 55);
    run_all(1, 0);
    guard = 0;
    while (mon_words < base + 3 && guard < 200) begin @(posedge ap_clk); guard++; end
    chk("rst_mid_reached", int'(mon_words >= base + 3), 1);
    #1;
    gready = 1'b0;
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("rst_mid_tvalid", int'(gvalid), 0);
    chk("rst_mid_pcnt", int'(pcnt), 0);
    chk("rst_mid_tready0", int'(tr[0]), 0);
    sb.delete();
    pkts_pushed = 0;
    repeat (3) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    rdy_mode = 0;
    seen = 0;
    repeat (12) begin
      @(negedge ap_clk);
      if (gvalid) seen = 1;
    end
    chk("post_rst_silent", seen, 0);
    send_pkt(-1, -20, 40, 3, 9);
    run_all(1, 1);
    drain();
    chk("post_rst_pcnt", int'(pcnt), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
